// File: rtl/regfile_pkg.sv
// Purpose : shared types and sizes for the integer register-file write-back path.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package regfile_pkg;

    localparam int XLEN = 64;
    localparam int NREG = 32;

    typedef logic [4:0] reg_idx_t;

    // One write-back beat: destination index plus data.
    typedef struct packed {
        reg_idx_t          rd;
        logic [XLEN-1:0]   data;
    } wb_beat_t;

endpackage : regfile_pkg

// File: rtl/regfile_scoreboard.sv
// Purpose : busy vector of destinations with long-latency writes outstanding, plus RAW/WAW compare.
// Latency : set/clear visible the cycle after; stall is combinational from current busy.
// Backpressure: stall holds issue while any source or the destination is busy.
// Ports   : clk/rst_n; set_en/set_idx (issue of a long op); clr_en/clr_idx (long write-back);
//           valid/rs1/rs2/rd (issuing instruction); stall (hazard against current busy).
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     set_en,
    input  reg_idx_t set_idx,
    input  logic     clr_en,
    input  reg_idx_t clr_idx,
    input  logic     valid,
    input  reg_idx_t rs1,
    input  reg_idx_t rs2,
    input  reg_idx_t rd,
    output logic     stall
);

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;

    // Clear applied first so a same-index set wins; x0 can never be busy.
    always_comb begin
        busy_nxt = busy;
        if (clr_en) begin
            busy_nxt[clr_idx] = 1'b0;
        end
        if (set_en) begin
            busy_nxt[set_idx] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // busy[0] is always 0, so index 0 never raises a hazard on either path.
    logic raw;
    logic waw;
    assign raw   = busy[rs1] || busy[rs2];
    assign waw   = busy[rd];
    assign stall = valid && (raw || waw);

endmodule : regfile_scoreboard

// File: rtl/regfile_wb_ctrl.sv
// Purpose : arbitrates ALU (wb0) and long-latency (wb1) write-back onto one RF write port,
//           tracks long-latency destinations for hazard stalls, forwards the in-flight write.
// Latency : transfer in cycle N -> rf_we/rf_rd/rf_wdata in N+1; forwarding is combinational.
// Backpressure: wb0 preferred; wb1 wins once refused MAX_AGE cycles; iss_stall on RAW/WAW.
// Ports   : wb0_*/wb1_* valid-ready write-back sources; iss_* issue-stage indices and stall;
//           rf_rs*_data in / fwd_rs*_data out operand path; rf_we/rf_rd/rf_wdata registered write.
module regfile_wb_ctrl
    import regfile_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int NREG    = 32,
    parameter int MAX_AGE = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wb0_valid,
    output logic            wb0_ready,
    input  logic [4:0]      wb0_rd,
    input  logic [XLEN-1:0] wb0_data,
    input  logic            wb1_valid,
    output logic            wb1_ready,
    input  logic [4:0]      wb1_rd,
    input  logic [XLEN-1:0] wb1_data,
    input  logic            iss_valid,
    input  logic            iss_long,
    input  logic [4:0]      iss_rd,
    input  logic [4:0]      iss_rs1,
    input  logic [4:0]      iss_rs2,
    output logic            iss_stall,
    input  logic [XLEN-1:0] rf_rs1_data,
    input  logic [XLEN-1:0] rf_rs2_data,
    output logic [XLEN-1:0] fwd_rs1_data,
    output logic [XLEN-1:0] fwd_rs2_data,
    output logic            rf_we,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_wdata
);

    // ---------------- arbitration ----------------
    logic [3:0] age;
    logic       starve;
    logic       wb0_xfer;
    logic       wb1_xfer;
    logic       xfer;
    wb_beat_t   win;

    assign starve    = (age == 4'(MAX_AGE));
    // wb1 may win only when wb0 is idle or wb1 has waited long enough; the two
    // ready terms are mutually exclusive whenever both sources are valid.
    assign wb0_ready = !(starve && wb1_valid);
    assign wb1_ready = !wb0_valid || starve;
    assign wb0_xfer  = wb0_valid && wb0_ready;
    assign wb1_xfer  = wb1_valid && wb1_ready;
    assign xfer      = wb0_xfer || wb1_xfer;

    always_comb begin
        win = '{rd: wb0_rd, data: wb0_data};
        if (wb1_xfer) begin
            win = '{rd: wb1_rd, data: wb1_data};
        end
    end

    // Counts refused wb1 cycles, saturating so starve stays asserted until wb1 moves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age <= '0;
        end else if (wb1_xfer) begin
            age <= '0;
        end else if (wb1_valid && !wb1_ready && (age != 4'(MAX_AGE))) begin
            age <= age + 4'd1;
        end
    end

    // ---------------- output stage ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= xfer && (win.rd != 5'd0);
            if (xfer) begin
                rf_rd    <= win.rd;
                rf_wdata <= win.data;
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic set_en;
    assign set_en = iss_valid && iss_long && !iss_stall && (iss_rd != 5'd0);

    regfile_scoreboard #(
        .NREG (NREG)
    ) u_sb (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_en  (set_en),
        .set_idx (iss_rd),
        .clr_en  (wb1_xfer),
        .clr_idx (wb1_rd),
        .valid   (iss_valid),
        .rs1     (iss_rs1),
        .rs2     (iss_rs2),
        .rd      (iss_rd),
        .stall   (iss_stall)
    );

    // ---------------- forwarding ----------------
    // The register file only holds the in-flight write from the following cycle,
    // so the registered write is bypassed onto matching operand reads.
    assign fwd_rs1_data = (rf_we && (rf_rd == iss_rs1) && (iss_rs1 != 5'd0)) ? rf_wdata : rf_rs1_data;
    assign fwd_rs2_data = (rf_we && (rf_rd == iss_rs2) && (iss_rs2 != 5'd0)) ? rf_wdata : rf_rs2_data;

endmodule : regfile_wb_ctrl

// File: tb/tb_regfile_wb_ctrl.sv
module tb_regfile_wb_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb0_valid;
    logic        wb0_ready;
    logic [4:0]  wb0_rd;
    logic [63:0] wb0_data;
    logic        wb1_valid;
    logic        wb1_ready;
    logic [4:0]  wb1_rd;
    logic [63:0] wb1_data;
    logic        iss_valid;
    logic        iss_long;
    logic [4:0]  iss_rd;
    logic [4:0]  iss_rs1;
    logic [4:0]  iss_rs2;
    logic        iss_stall;
    logic [63:0] rf_rs1_data;
    logic [63:0] rf_rs2_data;
    logic [63:0] fwd_rs1_data;
    logic [63:0] fwd_rs2_data;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [63:0] rf_wdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    regfile_wb_ctrl #(
        .XLEN    (64),
        .NREG    (32),
        .MAX_AGE (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wb0_valid    (wb0_valid),
        .wb0_ready    (wb0_ready),
        .wb0_rd       (wb0_rd),
        .wb0_data     (wb0_data),
        .wb1_valid    (wb1_valid),
        .wb1_ready    (wb1_ready),
        .wb1_rd       (wb1_rd),
        .wb1_data     (wb1_data),
        .iss_valid    (iss_valid),
        .iss_long     (iss_long),
        .iss_rd       (iss_rd),
        .iss_rs1      (iss_rs1),
        .iss_rs2      (iss_rs2),
        .iss_stall    (iss_stall),
        .rf_rs1_data  (rf_rs1_data),
        .rf_rs2_data  (rf_rs2_data),
        .fwd_rs1_data (fwd_rs1_data),
        .fwd_rs2_data (fwd_rs2_data),
        .rf_we        (rf_we),
        .rf_rd        (rf_rd),
        .rf_wdata     (rf_wdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write-back protocol: wb0 must never target a busy rd, wb1 must target a busy rd.
    always @(posedge clk) begin
        if (rst_n && wb0_valid && wb0_ready && (wb0_rd != 5'd0)) begin
            n_tests++;
            assert (dut.u_sb.busy[wb0_rd] === 1'b0) else begin
                n_fail++;
                $error("FAIL proto_wb0_busy: rd %0d is busy", wb0_rd);
            end
        end
        if (rst_n && wb1_valid && wb1_ready) begin
            n_tests++;
            assert (dut.u_sb.busy[wb1_rd] === 1'b1) else begin
                n_fail++;
                $error("FAIL proto_wb1_idle: rd %0d not busy", wb1_rd);
            end
        end
    end

    initial begin
        logic [4:0]  exp_rd;
        logic [63:0] exp_data;
        logic        exp_wb1;

        rst_n       = 1'b0;
        wb0_valid   = 1'b0; wb0_rd = '0; wb0_data = '0;
        wb1_valid   = 1'b0; wb1_rd = '0; wb1_data = '0;
        iss_valid   = 1'b0; iss_long = 1'b0; iss_rd = '0; iss_rs1 = '0; iss_rs2 = '0;
        rf_rs1_data = '0;   rf_rs2_data = '0;

        // ---- reset state ----
        #2;
        chk("rst_rf_we",     64'(rf_we),     64'd0);
        chk("rst_rf_rd",     64'(rf_rd),     64'd0);
        chk("rst_rf_wdata",  rf_wdata,       64'd0);
        chk("rst_wb0_ready", 64'(wb0_ready), 64'd1);
        chk("rst_wb1_ready", 64'(wb1_ready), 64'd1);
        chk("rst_iss_stall", 64'(iss_stall), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // ---- single wb0 beat ----
        wb0_valid = 1'b1; wb0_rd = 5'd5; wb0_data = 64'h1234;
        #1;
        chk("t1_wb0_ready", 64'(wb0_ready), 64'd1);
        chk("t1_wb1_ready", 64'(wb1_ready), 64'd0);
        tick();
        wb0_valid = 1'b0;
        chk("t1_rf_we",    64'(rf_we),  64'd1);
        chk("t1_rf_rd",    64'(rf_rd),  64'd5);
        chk("t1_rf_wdata", rf_wdata,    64'h1234);
        tick();
        chk("t1_rf_we_off",  64'(rf_we),  64'd0);
        chk("t1_rf_rd_hold", 64'(rf_rd),  64'd5);
        chk("t1_wdata_hold", rf_wdata,    64'h1234);

        // ---- arbitration / starvation: two long ops outstanding (x10, x11) ----
        iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd10;
        #1;
        chk("t2_iss10_nostall", 64'(iss_stall), 64'd0);
        tick();
        iss_rd = 5'd11;
        #1;
        chk("t2_iss11_nostall", 64'(iss_stall), 64'd0);
        tick();
        iss_valid = 1'b0; iss_long = 1'b0; iss_rd = '0;
        wb1_valid = 1'b1; wb1_rd = 5'd10; wb1_data = 64'hB1;
        wb0_valid = 1'b1; wb0_rd = 5'd6;
        for (int i = 0; i < 10; i++) begin
            wb0_data = 64'h60 + 64'(i);
            exp_wb1  = (i == 4) || (i == 9);
            #1;
            chk($sformatf("t2_wb0_ready_%0d", i), 64'(wb0_ready), 64'(!exp_wb1));
            chk($sformatf("t2_wb1_ready_%0d", i), 64'(wb1_ready), 64'(exp_wb1));
            exp_rd   = exp_wb1 ? wb1_rd : 5'd6;
            exp_data = exp_wb1 ? wb1_data : 64'h60 + 64'(i);
            tick();
            chk($sformatf("t2_rf_rd_%0d", i),    64'(rf_rd), 64'(exp_rd));
            chk($sformatf("t2_rf_wdata_%0d", i), rf_wdata,   exp_data);
            if (i == 4) begin
                wb1_rd = 5'd11; wb1_data = 64'hB2;
            end
        end
        wb0_valid = 1'b0; wb1_valid = 1'b0;
        tick();

        // ---- RAW hazard with forwarding ----
        iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd7; iss_rs1 = 5'd0; iss_rs2 = 5'd0;
        #1;
        chk("t3_long7_nostall", 64'(iss_stall), 64'd0);
        tick();
        iss_long = 1'b0; iss_rd = 5'd8; iss_rs1 = 5'd7; iss_rs2 = 5'd0;
        rf_rs1_data = 64'h5555; rf_rs2_data = 64'h77;
        #1;
        chk("t3_raw_stall_a", 64'(iss_stall), 64'd1);
        tick();
        chk("t3_raw_stall_b", 64'(iss_stall), 64'd1);
        wb1_valid = 1'b1; wb1_rd = 5'd7; wb1_data = 64'hAA;
        #1;
        chk("t3_wb1_ready", 64'(wb1_ready), 64'd1);
        chk("t3_raw_stall_c", 64'(iss_stall), 64'd1);
        tick();
        wb1_valid = 1'b0;
        #1;
        chk("t3_nostall",   64'(iss_stall), 64'd0);
        chk("t3_rf_we",     64'(rf_we),     64'd1);
        chk("t3_fwd_rs1",   fwd_rs1_data,   64'hAA);
        chk("t3_fwd_rs2",   fwd_rs2_data,   64'h77);
        tick();
        rf_rs1_data = 64'hAA;
        #1;
        chk("t3_rf_we_off", 64'(rf_we),     64'd0);
        chk("t3_rs1_rf",    fwd_rs1_data,   64'hAA);
        iss_valid = 1'b0;
        tick();

        // ---- write to x0 ----
        wb0_valid = 1'b1; wb0_rd = 5'd0; wb0_data = 64'hFFFF;
        #1;
        chk("t4_wb0_ready", 64'(wb0_ready), 64'd1);
        tick();
        wb0_valid = 1'b0;
        chk("t4_rf_we_x0", 64'(rf_we),  64'd0);
        chk("t4_rf_rd_x0", 64'(rf_rd),  64'd0);
        chk("t4_wdata_x0", rf_wdata,    64'hFFFF);
        iss_valid = 1'b1; iss_long = 1'b0; iss_rd = 5'd4; iss_rs1 = 5'd0; iss_rs2 = 5'd0;
        rf_rs1_data = 64'd0;
        #1;
        chk("t4_rs0_nostall", 64'(iss_stall), 64'd0);
        chk("t4_rs0_fwd",     fwd_rs1_data,   64'd0);
        tick();
        iss_valid = 1'b0;

        // ---- WAW hazard ----
        iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd3; iss_rs1 = 5'd0; iss_rs2 = 5'd0;
        tick();
        iss_long = 1'b0; iss_rd = 5'd3; iss_rs1 = 5'd1; iss_rs2 = 5'd2;
        rf_rs1_data = 64'h11; rf_rs2_data = 64'h22;
        #1;
        chk("t5_waw_stall_a", 64'(iss_stall), 64'd1);
        tick();
        chk("t5_waw_stall_b", 64'(iss_stall), 64'd1);
        wb1_valid = 1'b1; wb1_rd = 5'd3; wb1_data = 64'h33;
        tick();
        wb1_valid = 1'b0;
        #1;
        chk("t5_waw_clear", 64'(iss_stall), 64'd0);
        chk("t5_fwd_rs1",   fwd_rs1_data,   64'h11);
        chk("t5_rf_rd",     64'(rf_rd),     64'd3);
        tick();
        iss_valid = 1'b0;

        // ---- reset mid-stream ----
        iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd9; iss_rs1 = 5'd0; iss_rs2 = 5'd0;
        tick();
        iss_valid = 1'b0; iss_long = 1'b0;
        wb0_valid = 1'b1; wb0_rd = 5'd12; wb0_data = 64'hC;
        tick();
        wb0_valid = 1'b0;
        iss_valid = 1'b1; iss_rd = 5'd13; iss_rs1 = 5'd9;
        #1;
        chk("t6_pre_rf_we",  64'(rf_we),     64'd1);
        chk("t6_pre_stall",  64'(iss_stall), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_rf_we",  64'(rf_we),     64'd0);
        chk("t6_rst_rf_rd",  64'(rf_rd),     64'd0);
        chk("t6_rst_wdata",  rf_wdata,       64'd0);
        chk("t6_rst_stall",  64'(iss_stall), 64'd0);
        #1;
        rst_n = 1'b1;
        tick();
        chk("t6_post_stall", 64'(iss_stall), 64'd0);
        chk("t6_post_rf_we", 64'(rf_we),     64'd0);
        iss_valid = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_regfile_wb_ctrl
